// File: rtl/timer_sched.sv
// timer_sched: shared delay timer for NREQ requesters.
// Requests are arbitrated round-robin onto one down-counter (and prescaler).
// The winner gets a registered one-hot grant and, when its delay expires,
// a single-cycle done pulse.
//
// Handshake: req[i] is a level that the requester holds high until it sees
// done[i] or until it gives up. Dropping req[i] while it is granted (LOAD or
// RUN) aborts the delay silently. Dropping it in the DONE cycle does not
// cancel the pulse that is already being issued.
//
// Build option TIMER_SCHED_PRESCALE_EN:
//   defined   - a 0..PRESCALE-1 prescaler produces one tick every PRESCALE
//               clocks while running, and the counter steps on that tick.
//   undefined - no prescaler. tick is high on every RUN cycle, so the counter
//               steps every clock. This build is meant for fast simulation.
module timer_sched #(
    parameter int NREQ     = 4,
    parameter int CNT_W    = 25,
    parameter int PRESCALE = 20000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CNT_W-1:0] dly,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic [NREQ-1:0]       done,
    output logic                  tick
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [PTR_W-1:0]  gidx_q, gidx_d;   // index of the current winner
    logic [PTR_W-1:0]  ptr_q, ptr_d;     // round-robin search start
    logic [CNT_W-1:0]  count_q, count_d;

    logic              pick_valid;
    logic [PTR_W-1:0]  pick_idx;
    logic [PTR_W-1:0]  gidx_next;
    logic [CNT_W-1:0]  dly_sel;
    logic              req_held;
    logic              tick_w;

    function automatic logic [NREQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

`ifdef TIMER_SCHED_PRESCALE_EN
    localparam int PRE_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    logic [PRE_W-1:0] pre_q, pre_d;

    assign tick_w = (state_q == S_RUN) && (pre_q == PRE_W'(PRESCALE - 1));

    // Prescaler: counts only in RUN, wraps on tick, held at zero otherwise.
    always_comb begin
        pre_d = '0;
        if (state_q == S_RUN) begin
            if (tick_w) begin
                pre_d = '0;
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    // PRESCALE only shapes the tick when the prescaler is built in; it is
    // always >= 2, so this is simply "tick on every RUN cycle".
    assign tick_w = (state_q == S_RUN) && (PRESCALE != 0);
`endif

    assign dly_sel   = dly[gidx_q*CNT_W +: CNT_W];
    assign req_held  = req[gidx_q];
    assign gidx_next = (gidx_q == PTR_W'(NREQ - 1)) ? '0 : gidx_q + PTR_W'(1);

    // Round-robin pick: first set req bit searching upward from ptr_q, wrapping.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!pick_valid && req[(int'(ptr_q) + k) % NREQ]) begin
                pick_valid = 1'b1;
                pick_idx   = PTR_W'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    // Scheduler FSM next state, grant, done pulse, pointer and counter.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        unique case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    gnt_d   = onehot(pick_idx);
                    gidx_d  = pick_idx;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!req_held) begin
                    // Abandoned before the delay started.
                    gnt_d   = '0;
                    ptr_d   = gidx_next;
                    state_d = S_IDLE;
                end else begin
                    count_d = dly_sel;
                    if (dly_sel == '0) begin
                        gnt_d   = '0;
                        done_d  = onehot(gidx_q);
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (!req_held) begin
                    // Abandoned mid-delay: no done pulse.
                    gnt_d   = '0;
                    ptr_d   = gidx_next;
                    state_d = S_IDLE;
                end else if (tick_w) begin
                    // A zero count is never decremented.
                    if (count_q != '0) begin
                        count_d = count_q - CNT_W'(1);
                    end
                    if (count_q == CNT_W'(1)) begin
                        gnt_d   = '0;
                        done_d  = onehot(gidx_q);
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                ptr_d   = gidx_next;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, grant, done, pointer and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign busy = (|gnt_q) || (state_q == S_DONE);
    assign tick = tick_w;

endmodule

// File: tb/tb_timer_sched.sv
// tb_timer_sched: directed vectors for timer_sched (NREQ=4, CNT_W=8, PRESCALE=4).
// Latencies are scaled by T, the clocks per tick of the selected build.
module tb_timer_sched;

  localparam int NREQ     = 4;
  localparam int CNT_W    = 8;
  localparam int PRESCALE = 4;
`ifdef TIMER_SCHED_PRESCALE_EN
  localparam int T = PRESCALE;
`else
  localparam int T = 1;
`endif

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*CNT_W-1:0] dly;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic [NREQ-1:0]       done;
  logic                  tick;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [NREQ-1:0]       req;
    logic [NREQ*CNT_W-1:0] dly;
    logic [NREQ-1:0]       exp_gnt;
    int                    exp_d;
    string                 name;
  } vec_t;

  vec_t vecs[7];

  timer_sched #(
    .NREQ     (NREQ),
    .CNT_W    (CNT_W),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .dly   (dly),
    .gnt   (gnt),
    .busy  (busy),
    .done  (done),
    .tick  (tick)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One request from an IDLE cycle: grant next cycle, done after d ticks,
  // then release req and confirm the block goes idle.
  task automatic run_txn(input logic [NREQ-1:0] r, input logic [NREQ*CNT_W-1:0] d,
                         input logic [NREQ-1:0] eg, input int ed, input string nm);
    int waited;
    int ticks;
    int first_tick;
    bit found;
    waited     = 1;
    ticks      = 0;
    first_tick = -1;
    found      = 1'b0;
    req = r;
    dly = d;
    step();
    chk({nm, "_gnt"}, 32'(gnt), 32'(eg));
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    while (!found && waited < 2000) begin
      if (tick) begin
        ticks++;
        if (first_tick < 0) first_tick = waited;
      end
      step();
      waited++;
      if (done != '0) found = 1'b1;
    end
    chk({nm, "_seen"}, 32'(found), 32'd1);
    chk({nm, "_done"}, 32'(done), 32'(eg));
    chk({nm, "_lat"}, 32'(waited), 32'(ed * T + 2));
    chk({nm, "_gnt_in_done"}, 32'(gnt), 32'd0);
    chk({nm, "_ticks"}, 32'(ticks), 32'(ed));
    if (ed > 0) chk({nm, "_first_tick"}, 32'(first_tick), 32'(T + 1));
    req = '0;
    step();
    chk({nm, "_busy_after"}, 32'(busy), 32'd0);
    chk({nm, "_done_after"}, 32'(done), 32'd0);
  endtask

  // All four held high with dly=1: grants rotate 0,1,2,3,0.
  task automatic run_rr();
    int order[5];
    int k;
    int cnt;
    int last;
    order = '{0, 1, 2, 3, 0};
    k     = 0;
    cnt   = 0;
    last  = 0;
    req = 4'b1111;
    dly = {8'd1, 8'd1, 8'd1, 8'd1};
    while (k < 5 && cnt < 200) begin
      step();
      cnt++;
      if (done != '0) begin
        chk("rr_done", 32'(done), 32'(4'b0001 << order[k]));
        if (k > 0) chk("rr_spacing", 32'(cnt - last), 32'(T + 3));
        last = cnt;
        k++;
      end
    end
    chk("rr_count", 32'(k), 32'd5);
    req = '0;
    step();
    chk("rr_busy_after", 32'(busy), 32'd0);
  endtask

  // Requester 0 abandons during RUN; pointer must move to 1.
  task automatic run_abort();
    logic [NREQ-1:0] acc;
    req = 4'b0001;
    dly = {8'd0, 8'd0, 8'd0, 8'd8};
    step();
    chk("abort_gnt", 32'(gnt), 32'b0001);
    repeat (4) step();
    chk("abort_busy_run", 32'(busy), 32'd1);
    req = '0;
    step();
    chk("abort_gnt_clr", 32'(gnt), 32'd0);
    chk("abort_busy_clr", 32'(busy), 32'd0);
    acc = '0;
    repeat (12 * T) begin
      acc |= done;
      step();
    end
    chk("abort_no_done", 32'(acc), 32'd0);
    run_txn(4'b0011, {8'd0, 8'd0, 8'd1, 8'd1}, 4'b0010, 1, "abort_ptr");
  endtask

  // Reset during RUN of requester 2 (pointer was 2); afterwards 1011 must
  // go to requester 0, showing the pointer returned to 0.
  task automatic run_reset();
    logic [NREQ-1:0] acc;
    req = 4'b0100;
    dly = {8'd0, 8'd10, 8'd0, 8'd0};
    step();
    chk("rst_gnt", 32'(gnt), 32'b0100);
    repeat (3) step();
    reset = 1'b1;
    step();
    chk("rst_gnt_clr", 32'(gnt), 32'd0);
    chk("rst_done_clr", 32'(done), 32'd0);
    chk("rst_busy_clr", 32'(busy), 32'd0);
    chk("rst_tick_clr", 32'(tick), 32'd0);
    reset = 1'b0;
    req   = '0;
    acc   = '0;
    repeat (50) begin
      acc |= done;
      step();
    end
    chk("rst_no_done", 32'(acc), 32'd0);
    run_txn(4'b1011, {8'd2, 8'd0, 8'd1, 8'd3}, 4'b0001, 3, "rst_ptr");
  endtask

  initial begin
    // pointer trace through the table: 0 ->1 ->3 ->2 ->0 ->2 ->1 ->0
    vecs[0] = '{4'b0001, {8'd0, 8'd0, 8'd0, 8'd3}, 4'b0001, 3, "v0_single"};
    vecs[1] = '{4'b0100, {8'd0, 8'd0, 8'd0, 8'd0}, 4'b0100, 0, "v1_zero"};
    vecs[2] = '{4'b0010, {8'd0, 8'd0, 8'd2, 8'd0}, 4'b0010, 2, "v2_req1"};
    vecs[3] = '{4'b1001, {8'd1, 8'd0, 8'd0, 8'd5}, 4'b1000, 1, "v3_wrap"};
    vecs[4] = '{4'b0110, {8'd0, 8'd7, 8'd4, 8'd0}, 4'b0010, 4, "v4_from0"};
    vecs[5] = '{4'b0011, {8'd0, 8'd0, 8'd9, 8'd0}, 4'b0001, 0, "v5_wrap0"};
    vecs[6] = '{4'b1000, {8'd6, 8'd0, 8'd0, 8'd0}, 4'b1000, 6, "v6_req3"};

    reset = 1'b1;
    req   = '0;
    dly   = '0;
    repeat (3) step();
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_tick", 32'(tick), 32'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].req, vecs[i].dly, vecs[i].exp_gnt, vecs[i].exp_d, vecs[i].name);
    end

    run_rr();
    run_abort();
    run_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
